// File: rtl/fc2_act_packer.sv
// FC2 activation packer: packs 1-bit activations LSB-first into words, buffered in a show-ahead FIFO.
// Optional FC2_PACK_POPCNT_EN adds a per-word popcount stored alongside each word.
module fc2_act_packer #(
  parameter int WORD_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         bit_in,
  input  logic                         bit_valid_in,
  input  logic                         bit_last_in,
  output logic [WORD_W-1:0]            word_out,
  output logic                         word_valid_out,
  input  logic                         word_ready_in,
  output logic                         word_last_out,
  output logic [$clog2(WORD_W+1)-1:0]  word_nbits_out,
  output logic                         overflow_out
`ifdef FC2_PACK_POPCNT_EN
  ,
  output logic [$clog2(WORD_W+1)-1:0]  popcnt_out
`endif
);

  localparam int CW = $clog2(WORD_W + 1);
  localparam int FW = $clog2(WORD_W);
  localparam int AW = $clog2(DEPTH);

  logic [WORD_W-1:0] pack_q, pack_d;
  logic [FW-1:0]     fill_q, fill_d;
  logic [AW:0]       wr_q, wr_d;
  logic [AW:0]       rd_q, rd_d;
  logic              ovf_q, ovf_d;

  logic [WORD_W-1:0] word_mem_q [DEPTH];
  logic [WORD_W-1:0] word_mem_d [DEPTH];
  logic              last_mem_q [DEPTH];
  logic              last_mem_d [DEPTH];
  logic [CW-1:0]     nbits_mem_q [DEPTH];
  logic [CW-1:0]     nbits_mem_d [DEPTH];

`ifdef FC2_PACK_POPCNT_EN
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [CW-1:0]     pc_mem_q [DEPTH];
  logic [CW-1:0]     pc_mem_d [DEPTH];
  logic [CW-1:0]     done_pc;
`endif

  logic              full;
  logic              empty;
  logic              pop;
  logic              done;
  logic              push_ok;
  logic [WORD_W-1:0] done_word;
  logic [CW-1:0]     done_nbits;
  logic [AW-1:0]     wr_idx;
  logic [AW-1:0]     rd_idx;

  assign wr_idx = wr_q[AW-1:0];
  assign rd_idx = rd_q[AW-1:0];
  assign empty  = (wr_q == rd_q);
  assign full   = (wr_idx == rd_idx) && (wr_q[AW] != rd_q[AW]);
  assign pop    = !empty && word_ready_in;

  always_comb begin
    done_word         = pack_q;
    done_word[fill_q] = bit_in;
    done_nbits        = CW'(fill_q) + CW'(1);
    done    = bit_valid_in && (bit_last_in || (fill_q == FW'(WORD_W - 1)));
    push_ok = done && (!full || pop);
`ifdef FC2_PACK_POPCNT_EN
    done_pc = cnt_q + CW'(bit_in);
`endif
  end

  always_comb begin
    pack_d      = pack_q;
    fill_d      = fill_q;
    wr_d        = wr_q;
    rd_d        = rd_q;
    ovf_d       = ovf_q;
    word_mem_d  = word_mem_q;
    last_mem_d  = last_mem_q;
    nbits_mem_d = nbits_mem_q;
`ifdef FC2_PACK_POPCNT_EN
    cnt_d    = cnt_q;
    pc_mem_d = pc_mem_q;
`endif
    if (bit_valid_in) begin
      if (done) begin
        pack_d = '0;
        fill_d = '0;
`ifdef FC2_PACK_POPCNT_EN
        cnt_d  = '0;
`endif
      end else begin
        pack_d = done_word;
        fill_d = fill_q + FW'(1);
`ifdef FC2_PACK_POPCNT_EN
        cnt_d  = done_pc;
`endif
      end
    end
    if (push_ok) begin
      word_mem_d[wr_idx]  = done_word;
      last_mem_d[wr_idx]  = bit_last_in;
      nbits_mem_d[wr_idx] = done_nbits;
`ifdef FC2_PACK_POPCNT_EN
      pc_mem_d[wr_idx]    = done_pc;
`endif
      wr_d = wr_q + (AW+1)'(1);
    end
    if (pop) begin
      rd_d = rd_q + (AW+1)'(1);
    end
    // a full FIFO with no pop loses the word; packing carries on regardless
    if (done && full && !pop) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pack_q <= '0;
      fill_q <= '0;
      wr_q   <= '0;
      rd_q   <= '0;
      ovf_q  <= 1'b0;
`ifdef FC2_PACK_POPCNT_EN
      cnt_q  <= '0;
`endif
    end else begin
      pack_q <= pack_d;
      fill_q <= fill_d;
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      ovf_q  <= ovf_d;
`ifdef FC2_PACK_POPCNT_EN
      cnt_q  <= cnt_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    word_mem_q  <= word_mem_d;
    last_mem_q  <= last_mem_d;
    nbits_mem_q <= nbits_mem_d;
`ifdef FC2_PACK_POPCNT_EN
    pc_mem_q    <= pc_mem_d;
`endif
  end

  // head fields are forced to zero when empty so reset state is well defined
  assign word_valid_out = !empty;
  assign word_out       = empty ? '0 : word_mem_q[rd_idx];
  assign word_last_out  = empty ? 1'b0 : last_mem_q[rd_idx];
  assign word_nbits_out = empty ? '0 : nbits_mem_q[rd_idx];
  assign overflow_out   = ovf_q;
`ifdef FC2_PACK_POPCNT_EN
  assign popcnt_out     = empty ? '0 : pc_mem_q[rd_idx];
`endif

endmodule

// File: tb/tb_fc2_act_packer.sv
// Scoreboard bench for fc2_act_packer (WORD_W=32, DEPTH=4).
// Directed vectors; a negedge monitor pops expected words on each handshake.
module tb_fc2_act_packer;

  localparam int W  = 32;
  localparam int D  = 4;
  localparam int CW = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic          bit_in;
  logic          bit_valid_in;
  logic          bit_last_in;
  logic [W-1:0]  word_out;
  logic          word_valid_out;
  logic          word_ready_in;
  logic          word_last_out;
  logic [CW-1:0] word_nbits_out;
  logic          overflow_out;
`ifdef FC2_PACK_POPCNT_EN
  logic [CW-1:0] popcnt_out;
`endif

  fc2_act_packer #(.WORD_W(W), .DEPTH(D)) dut (
    .clk            (clk),
    .rst            (rst),
    .bit_in         (bit_in),
    .bit_valid_in   (bit_valid_in),
    .bit_last_in    (bit_last_in),
    .word_out       (word_out),
    .word_valid_out (word_valid_out),
    .word_ready_in  (word_ready_in),
    .word_last_out  (word_last_out),
    .word_nbits_out (word_nbits_out),
    .overflow_out   (overflow_out)
`ifdef FC2_PACK_POPCNT_EN
    ,
    .popcnt_out     (popcnt_out)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0]  w;
    logic          last;
    logic [CW-1:0] nb;
    logic [CW-1:0] pc;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic void push_exp(input logic [W-1:0] w, input logic l,
                                   input int nb, input int pc);
    exp_t e;
    e.w    = w;
    e.last = l;
    e.nb   = CW'(nb);
    e.pc   = CW'(pc);
    q.push_back(e);
  endfunction

  always @(negedge clk) begin
    if (!rst && word_valid_out && word_ready_in) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_word: got %0h want none", word_out);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("mon_word", 64'(word_out), 64'(e.w));
        check("mon_last", 64'(word_last_out), 64'(e.last));
        check("mon_nbits", 64'(word_nbits_out), 64'(e.nb));
`ifdef FC2_PACK_POPCNT_EN
        check("mon_popcnt", 64'(popcnt_out), 64'(e.pc));
`endif
      end
    end
  end

  task automatic send_bit(input logic b, input logic l);
    bit_in       = b;
    bit_valid_in = 1'b1;
    bit_last_in  = l;
    @(posedge clk);
    #1;
    bit_valid_in = 1'b0;
    bit_last_in  = 1'b0;
    bit_in       = 1'b0;
  endtask

  task automatic send_word(input logic [W-1:0] w, input int n, input logic l);
    for (int i = 0; i < n; i++) begin
      send_bit(w[i], l && (i == n - 1));
    end
  endtask

  task automatic wait_empty(input string nm);
    int n;
    n = 0;
    while ((q.size() != 0 || word_valid_out) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check(nm, 64'(q.size()), 64'd0);
  endtask

  task automatic check_zero(input string nm);
    check({nm, "_valid"}, 64'(word_valid_out), 64'd0);
    check({nm, "_word"}, 64'(word_out), 64'd0);
    check({nm, "_last"}, 64'(word_last_out), 64'd0);
    check({nm, "_nbits"}, 64'(word_nbits_out), 64'd0);
    check({nm, "_ovf"}, 64'(overflow_out), 64'd0);
`ifdef FC2_PACK_POPCNT_EN
    check({nm, "_popcnt"}, 64'(popcnt_out), 64'd0);
`endif
  endtask

  initial begin
    logic [W-1:0] v;
    rst           = 1'b1;
    bit_in        = 1'b0;
    bit_valid_in  = 1'b0;
    bit_last_in   = 1'b0;
    word_ready_in = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    rst = 1'b0;

    // alternating 1,0 word; exact one-cycle visibility with ready high
    v = 32'h5555_5555;
    push_exp(v, 1'b0, 32, 16);
    send_word(v, 31, 1'b0);
    check("t1_pre_valid", 64'(word_valid_out), 64'd0);
    send_bit(v[31], 1'b0);
    check("t1_latency", 64'(word_valid_out), 64'd1);
    @(posedge clk);
    #1;
    check("t1_one_cycle", 64'(word_valid_out), 64'd0);

    // 40 ones with last on the 40th
    push_exp(32'hFFFF_FFFF, 1'b0, 32, 32);
    push_exp(32'h0000_00FF, 1'b1, 8, 8);
    send_word(32'hFFFF_FFFF, 32, 1'b0);
    send_word(32'h0000_00FF, 8, 1'b1);
    wait_empty("t2_drain");

    // single bit with last at fill 0
    push_exp(32'h0000_0001, 1'b1, 1, 1);
    send_bit(1'b1, 1'b1);
    wait_empty("t6_drain");

    // full FIFO, fifth word completes in the same cycle as a pop
    word_ready_in = 1'b0;
    push_exp(32'h8000_0000, 1'b0, 32, 1);
    push_exp(32'hC000_0000, 1'b0, 32, 2);
    push_exp(32'hE000_0000, 1'b0, 32, 3);
    push_exp(32'hF000_0000, 1'b0, 32, 4);
    push_exp(32'hF800_0000, 1'b0, 32, 5);
    send_word(32'h8000_0000, 32, 1'b0);
    send_word(32'hC000_0000, 32, 1'b0);
    send_word(32'hE000_0000, 32, 1'b0);
    send_word(32'hF000_0000, 32, 1'b0);
    check("t4_full_valid", 64'(word_valid_out), 64'd1);
    check("t4_full_word", 64'(word_out), 64'h8000_0000);
    v = 32'hF800_0000;
    send_word(v, 31, 1'b0);
    word_ready_in = 1'b1;
    send_bit(v[31], 1'b0);
    word_ready_in = 1'b0;
    check("t4_no_ovf", 64'(overflow_out), 64'd0);
    check("t4_head", 64'(word_out), 64'hC000_0000);
    word_ready_in = 1'b1;
    wait_empty("t4_drain");

    // overflow: five words into a four-deep FIFO with no pops
    word_ready_in = 1'b0;
    push_exp(32'h0000_0001, 1'b0, 32, 1);
    push_exp(32'h0000_0003, 1'b0, 32, 2);
    push_exp(32'h0000_0007, 1'b0, 32, 3);
    push_exp(32'h0000_000F, 1'b0, 32, 4);
    send_word(32'h0000_0001, 32, 1'b0);
    send_word(32'h0000_0003, 32, 1'b0);
    send_word(32'h0000_0007, 32, 1'b0);
    send_word(32'h0000_000F, 32, 1'b0);
    check("t3_ovf_before", 64'(overflow_out), 64'd0);
    send_word(32'h0000_001F, 32, 1'b0);
    check("t3_ovf_after", 64'(overflow_out), 64'd1);
    word_ready_in = 1'b1;
    wait_empty("t3_drain");
    check("t3_ovf_sticky", 64'(overflow_out), 64'd1);

    // reset mid-vector with two words queued; bits during reset ignored
    word_ready_in = 1'b0;
    send_word(32'hA5A5_A5A5, 32, 1'b0);
    send_word(32'hA5A5_A5A5, 32, 1'b0);
    send_word(32'h0000_03FF, 10, 1'b0);
    check("t5_pre_valid", 64'(word_valid_out), 64'd1);
    rst          = 1'b1;
    bit_in       = 1'b1;
    bit_valid_in = 1'b1;
    @(posedge clk);
    #1;
    rst          = 1'b0;
    bit_in       = 1'b0;
    bit_valid_in = 1'b0;
    check_zero("t5_rst");
    word_ready_in = 1'b1;
    push_exp(32'h1234_5678, 1'b0, 32, 13);
    send_word(32'h1234_5678, 32, 1'b0);
    wait_empty("t5_drain");

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
